// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory bus between the datapath (master) and the memory responder (slave).
interface lc3_mem_if;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        mem_r;
    logic        ddr_valid;
    logic [15:0] ddr_data;

    modport master (
        output mem_en, mem_rw, address, data_in,
        input  data_out, mem_r, ddr_valid, ddr_data
    );

    modport slave (
        input  mem_en, mem_rw, address, data_in,
        output data_out, mem_r, ddr_valid, ddr_data
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder with programmable wait states and a one-cycle MEM_R completion pulse.
// Define LC3_MEM_MMIO_EN to decode the display registers DSR (xFE04) and DDR (xFE06).
//
//   state  | meaning
//   S_IDLE | waiting for MEM_EN; request latched on the accepting edge
//   S_WAIT | counting down wait states; bus inputs ignored
//   S_DONE | MEM_R high, read data valid; a write commits on the exit edge
module lc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    lc3_mem_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ddr_valid_q, ddr_valid_d;
    logic [15:0] ddr_data_q, ddr_data_d;

    logic [15:0] mem_q [2**ADDR_W];

    // The access being served: straight from the bus on the accepting edge
    // (zero wait states enter DONE directly), otherwise the latched copy.
    logic [15:0] acc_addr;
    logic        acc_rw;
    logic [15:0] acc_wdata;
    logic        hit_dsr;
    logic        hit_ddr;
    logic        enter_done;
    logic        mem_we;

    assign acc_addr  = (state_q == S_IDLE) ? bus.address : addr_q;
    assign acc_rw    = (state_q == S_IDLE) ? bus.mem_rw  : rw_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.data_in : wdata_q;

`ifdef LC3_MEM_MMIO_EN
    assign hit_dsr = (acc_addr == 16'hFE04);
    assign hit_ddr = (acc_addr == 16'hFE06);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[15:ADDR_W];
    assign hit_dsr        = 1'b0;
    assign hit_ddr        = 1'b0;
`endif

    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    assign mem_we     = !rst_i && (state_q == S_DONE) && rw_q && !hit_dsr && !hit_ddr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ddr_valid_d = 1'b0;
        ddr_data_d  = ddr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_en) begin
                    addr_d  = bus.address;
                    rw_d    = bus.mem_rw;
                    wdata_d = bus.data_in;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_done) begin
            if (!acc_rw) begin
                if (hit_dsr) begin
                    rdata_d = 16'h8000;
                end else if (hit_ddr) begin
                    rdata_d = ddr_data_q;
                end else begin
                    rdata_d = mem_q[acc_addr[ADDR_W-1:0]];
                end
            end else if (hit_ddr) begin
                ddr_data_d  = acc_wdata;
                ddr_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b0;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            ddr_valid_q <= 1'b0;
            ddr_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ddr_valid_q <= ddr_valid_d;
            ddr_data_q  <= ddr_data_d;
        end
    end

    // Array is deliberately outside the reset domain: RESET keeps its contents.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[addr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    assign bus.data_out  = rdata_q;
    assign bus.mem_r     = (state_q == S_DONE);
    assign bus.ddr_valid = ddr_valid_q;
    assign bus.ddr_data  = ddr_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: one instance with two wait states, one with none.
module tb_lc3_mem_responder;

    typedef struct packed {
        int          cyc;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q2[$];
    exp_t q0[$];

    lc3_mem_if if_w2();
    lc3_mem_if if_w0();

    lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_w2)
    );

    lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_w0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitors: every MEM_R pulse must match the head of its queue in cycle and read data.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (if_w2.mem_r) begin
                n_cmp++;
                if (q2.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_w2_unexpected: mem_r at cyc=%0d data_out=%h, required no pulse", cyc, if_w2.data_out);
                end else begin
                    e = q2.pop_front();
                    if (cyc != e.cyc || prev || (e.rd && if_w2.data_out !== e.data)) begin
                        n_bad++;
                        $display("FAIL sb_w2: cyc=%0d data_out=%h prev_mem_r=%b, required cyc=%0d data=%h (rd=%b)",
                                 cyc, if_w2.data_out, prev, e.cyc, e.data, e.rd);
                    end
                end
            end
            prev = if_w2.mem_r;
        end
    end

    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (if_w0.mem_r) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_w0_unexpected: mem_r at cyc=%0d data_out=%h, required no pulse", cyc, if_w0.data_out);
                end else begin
                    e = q0.pop_front();
                    if (cyc != e.cyc || prev || (e.rd && if_w0.data_out !== e.data)) begin
                        n_bad++;
                        $display("FAIL sb_w0: cyc=%0d data_out=%h prev_mem_r=%b, required cyc=%0d data=%h (rd=%b)",
                                 cyc, if_w0.data_out, prev, e.cyc, e.data, e.rd);
                    end
                end
            end
            prev = if_w0.mem_r;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One access on the two-wait-state instance; returns display strobe/data seen with MEM_R.
    task automatic acc2(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] ex, output logic dv, output logic [15:0] dd);
        int  a;
        bit  seen;
        @(negedge clk);
        if_w2.mem_en  = 1'b1;
        if_w2.mem_rw  = rw;
        if_w2.address = addr;
        if_w2.data_in = wd;
        @(posedge clk);
        #1;
        a = cyc;
        q2.push_back('{cyc: a + 2, rd: !rw, data: ex});
        seen = 0;
        dv   = 1'b0;
        dd   = 16'h0000;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_w2.mem_r) begin
                seen = 1;
                dv   = if_w2.ddr_valid;
                dd   = if_w2.ddr_data;
            end
        end
        if_w2.mem_en = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL acc2_timeout: no mem_r for addr %h, required pulse at cyc %0d", addr, a + 2);
        end
    endtask

    task automatic acc0(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] ex);
        int  a;
        bit  seen;
        @(negedge clk);
        if_w0.mem_en  = 1'b1;
        if_w0.mem_rw  = rw;
        if_w0.address = addr;
        if_w0.data_in = wd;
        @(posedge clk);
        #1;
        a = cyc;
        q0.push_back('{cyc: a, rd: !rw, data: ex});
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_w0.mem_r) seen = 1;
        end
        if_w0.mem_en = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL acc0_timeout: no mem_r for addr %h, required pulse at cyc %0d", addr, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        dv;
        logic [15:0] dd;
        int          a;
        int          b;

        if_w2.mem_en = 1'b0; if_w2.mem_rw = 1'b0; if_w2.address = 16'h0; if_w2.data_in = 16'h0;
        if_w0.mem_en = 1'b0; if_w0.mem_rw = 1'b0; if_w0.address = 16'h0; if_w0.data_in = 16'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_w2_data_out", if_w2.data_out, 16'h0000);
        chk("rst_w2_mem_r", {15'h0, if_w2.mem_r}, 16'h0000);
        chk("rst_w2_ddr_valid", {15'h0, if_w2.ddr_valid}, 16'h0000);
        chk("rst_w2_ddr_data", if_w2.ddr_data, 16'h0000);
        chk("rst_w0_data_out", if_w0.data_out, 16'h0000);
        chk("rst_w0_mem_r", {15'h0, if_w0.mem_r}, 16'h0000);

        // Two wait states: write then read back
        acc2(1'b1, 16'h0010, 16'h1234, 16'h0000, dv, dd);
        acc2(1'b0, 16'h0010, 16'h0000, 16'h1234, dv, dd);

        // Address wrap above bit 9
        acc2(1'b1, 16'h0403, 16'hAAAA, 16'h0000, dv, dd);
        acc2(1'b0, 16'h0003, 16'h0000, 16'hAAAA, dv, dd);

        // Zero wait states: write/read, then back-to-back with MEM_EN held
        acc0(1'b1, 16'h00FF, 16'hBEEF, 16'h0000);
        acc0(1'b0, 16'h00FF, 16'h0000, 16'hBEEF);
        @(negedge clk);
        if_w0.mem_en  = 1'b1;
        if_w0.mem_rw  = 1'b1;
        if_w0.address = 16'h0100;
        if_w0.data_in = 16'h1357;
        @(posedge clk);
        #1;
        a = cyc;
        q0.push_back('{cyc: a, rd: 1'b0, data: 16'h0000});
        @(negedge clk);
        if_w0.mem_rw = 1'b0;
        q0.push_back('{cyc: a + 2, rd: 1'b1, data: 16'h1357});
        repeat (2) @(negedge clk);
        if_w0.address = 16'h00FF;
        q0.push_back('{cyc: a + 4, rd: 1'b1, data: 16'hBEEF});
        repeat (2) @(negedge clk);
        if_w0.mem_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write: no pulse, no array update, data_out cleared
        acc2(1'b1, 16'h0020, 16'h1111, 16'h0000, dv, dd);
        acc2(1'b0, 16'h0010, 16'h0000, 16'h1234, dv, dd);
        @(negedge clk);
        if_w2.mem_en  = 1'b1;
        if_w2.mem_rw  = 1'b1;
        if_w2.address = 16'h0020;
        if_w2.data_in = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        if_w2.mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_data_out", if_w2.data_out, 16'h0000);
        repeat (4) @(negedge clk);
        acc2(1'b0, 16'h0020, 16'h0000, 16'h1111, dv, dd);

        // MEM_EN dropped mid-WAIT still completes once
        @(negedge clk);
        if_w2.mem_en  = 1'b1;
        if_w2.mem_rw  = 1'b0;
        if_w2.address = 16'h0010;
        @(posedge clk);
        #1;
        a = cyc;
        q2.push_back('{cyc: a + 2, rd: 1'b1, data: 16'h1234});
        @(negedge clk);
        if_w2.mem_en = 1'b0;
        repeat (3) @(negedge clk);

        // MEM_EN held past DONE starts a second access four cycles later
        @(negedge clk);
        if_w2.mem_en  = 1'b1;
        if_w2.mem_rw  = 1'b0;
        if_w2.address = 16'h0003;
        @(posedge clk);
        #1;
        b = cyc;
        q2.push_back('{cyc: b + 2, rd: 1'b1, data: 16'hAAAA});
        q2.push_back('{cyc: b + 6, rd: 1'b1, data: 16'hAAAA});
        for (int i = 0; i < 20 && cyc < b + 6; i++) @(negedge clk);
        if_w2.mem_en = 1'b0;
        repeat (2) @(negedge clk);

        // Display registers (or plain aliases without the MMIO option)
        acc2(1'b1, 16'h0206, 16'h7777, 16'h0000, dv, dd);
        acc2(1'b1, 16'h0204, 16'h2468, 16'h0000, dv, dd);
        acc2(1'b1, 16'hFE06, 16'h0041, 16'h0000, dv, dd);
`ifdef LC3_MEM_MMIO_EN
        chk("ddr_valid_at_done", {15'h0, dv}, 16'h0001);
        chk("ddr_data_at_done", dd, 16'h0041);
`else
        chk("ddr_valid_at_done", {15'h0, dv}, 16'h0000);
        chk("ddr_data_at_done", dd, 16'h0000);
`endif
        @(negedge clk);
        chk("ddr_valid_after", {15'h0, if_w2.ddr_valid}, 16'h0000);
`ifdef LC3_MEM_MMIO_EN
        acc2(1'b0, 16'h0206, 16'h0000, 16'h7777, dv, dd);
        acc2(1'b0, 16'hFE04, 16'h0000, 16'h8000, dv, dd);
`else
        acc2(1'b0, 16'h0206, 16'h0000, 16'h0041, dv, dd);
        acc2(1'b0, 16'hFE04, 16'h0000, 16'h2468, dv, dd);
`endif
        acc2(1'b0, 16'hFE06, 16'h0000, 16'h0041, dv, dd);

        repeat (4) @(negedge clk);
        n_cmp++;
        if (q2.size() != 0 || q0.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: pending w2=%0d w0=%0d, required 0 and 0", q2.size(), q0.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
